// File: rtl/instruction_fetch_unit.sv
// Purpose: sequential instruction fetch with a credit-gated memory request channel and an in-order response FIFO.
// Latency: a response accepted at edge N is presented on inst_* in the cycle after N (no bypass); redirect takes effect next cycle.
// Backpressure: requests stall while outstanding + buffered reaches DEPTH; the head holds while inst_ready is low.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [5:0]  OP,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic          r_active;
    logic [31:0]   r_fifo_data [DEPTH];
    logic [31:0]   r_fifo_pc   [DEPTH];

    logic [CW:0]   w_credit_sum;
    logic          w_req_fire;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_out_next;
    logic [31:0]   w_redirect_tgt;

    // Credit covers both buffered entries and requests still in flight, so a push can never find the FIFO full.
    assign w_credit_sum   = {1'b0, r_outstanding} + {1'b0, r_count};
    assign imem_req_valid = r_active && (w_credit_sum < L_DEPTH);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Responses are kept only when no stale requests remain and no redirect is flushing this cycle.
    assign w_push         = imem_rsp_valid && !redirect_valid && (r_discard == '0);
    assign w_pop          = inst_valid && inst_ready;
    assign w_out_next     = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
    assign w_redirect_tgt = redirect_pc & ~32'h3;

    // Empty FIFO presents an all-zero word, which decodes as a NOP.
    assign inst_valid = (r_count != '0);
    assign inst_data  = inst_valid ? r_fifo_data[r_rptr] : '0;
    assign inst_pc    = inst_valid ? r_fifo_pc[r_rptr]   : '0;
    assign OP         = inst_data[31:26];

    // Control state: fetch/response PCs, in-flight and discard counters, FIFO pointers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_active      <= 1'b0;
        end else begin
            r_active      <= 1'b1;
            r_outstanding <= w_out_next;
            if (redirect_valid) begin
                // Everything requested so far, including this cycle's accept, is now stale.
                r_fetch_pc <= w_redirect_tgt;
                r_rsp_pc   <= w_redirect_tgt;
                r_discard  <= w_out_next;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (imem_rsp_valid) begin
                    if (r_discard != '0) begin
                        r_discard <= r_discard - CW'(1);
                    end else begin
                        r_rsp_pc <= r_rsp_pc + 32'd4;
                    end
                end
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // FIFO storage; contents are qualified by r_count so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= imem_rsp_data;
            r_fifo_pc[r_wptr]   <= r_rsp_pc;
        end
    end

endmodule
